// File: rtl/lw_digest_out.sv
// lw_digest_out: captures, truncates, streams and zeroizes the engine digest; LW_DIGEST_TAG_CMP_EN adds a constant-time tag compare
module lw_digest_out #(
  parameter int WORD_W = 64,
  parameter int NWORDS = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NWORDS-1:0][WORD_W-1:0]  hash_i,
  input  logic                           done_i,
  input  logic                           abort_i,
  input  logic [3:0]                     nwords_i,
  input  logic                           half_last_i,
  output logic [WORD_W-1:0]              out_data_o,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic                           out_last_o,
  output logic                           busy_o,
  output logic                           overflow_o,
  output logic                           sent_o
`ifdef LW_DIGEST_TAG_CMP_EN
  ,
  input  logic [WORD_W-1:0]              exp_tag_i,
  output logic                           tag_ok_o,
  output logic                           tag_vld_o
`endif
);
  localparam int H = WORD_W / 2;
  typedef enum logic {IDLE, SEND} state_t;
  state_t state;
  logic [WORD_W-1:0] mem [NWORDS];
  logic [2:0] idx;
  logic [3:0] cnt;
  logic hl;
  logic last;
  logic hs;
  logic [3:0] n_sel;
  logic [WORD_W-1:0] mask;
  assign busy_o      = (state == SEND);
  assign out_valid_o = busy_o;
  assign last        = (cnt == 4'd1);
  assign out_last_o  = busy_o && last;
  assign hs          = busy_o && out_ready_i;
  assign n_sel       = (nwords_i == 4'd0 || nwords_i > 4'd8) ? 4'd8 : nwords_i;
  assign mask        = (last && hl) ? {{H{1'b1}}, {H{1'b0}}} : '1;
  assign out_data_o  = busy_o ? (mem[idx] & mask) : '0;
  always_ff @(posedge clk_i) begin
    sent_o <= 1'b0;
    if (rst_i || abort_i) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
      hl    <= 1'b0;
      for (int k = 0; k < NWORDS; k++) mem[k] <= '0;
      if (rst_i) overflow_o <= 1'b0;
    end else if (state == IDLE) begin
      if (done_i) begin
        for (int k = 0; k < NWORDS; k++) mem[k] <= hash_i[k];
        idx        <= 3'd7;
        cnt        <= n_sel;
        hl         <= half_last_i;
        overflow_o <= 1'b0;
        state      <= SEND;
      end
    end else begin
      if (done_i) overflow_o <= 1'b1;
      if (out_ready_i) begin
        if (last) begin
          for (int k = 0; k < NWORDS; k++) mem[k] <= '0;
          state  <= IDLE;
          sent_o <= 1'b1;
        end else begin
          mem[idx] <= '0;
          idx      <= idx - 3'd1;
          cnt      <= cnt - 4'd1;
        end
      end
    end
  end
`ifdef LW_DIGEST_TAG_CMP_EN
  logic [WORD_W-1:0] diff;
  logic [WORD_W-1:0] d;
  assign d = (out_data_o ^ exp_tag_i) & mask;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      diff      <= '0;
      tag_ok_o  <= 1'b0;
      tag_vld_o <= 1'b0;
    end else begin
      tag_vld_o <= 1'b0;
      if (abort_i) begin
        diff <= '0;
      end else if (state == IDLE && done_i) begin
        diff     <= '0;
        tag_ok_o <= 1'b0;
      end else if (hs) begin
        diff <= last ? '0 : (diff | d);
        if (last) begin
          tag_vld_o <= 1'b1;
          tag_ok_o  <= ((diff | d) == '0);
        end
      end
    end
  end
`endif
endmodule

// File: tb/tb_lw_digest_out.sv
// tb_lw_digest_out: random-data directed sequence against a queue model of the truncated digest stream
module tb_lw_digest_out;
  logic clk = 0;
  logic rst = 1;
  logic [7:0][63:0] hash = '0;
  logic done = 0;
  logic abort = 0;
  logic [3:0] nwords = 0;
  logic half_last = 0;
  logic [63:0] out_data;
  logic out_valid;
  logic out_ready = 0;
  logic out_last;
  logic busy;
  logic overflow;
  logic sent;
`ifdef LW_DIGEST_TAG_CMP_EN
  logic [63:0] exp_tag = '0;
  logic tag_ok;
  logic tag_vld;
  int flip_beat = -1;
`endif
  int total = 0;
  int bad = 0;
  logic [63:0] q[$];
  int ne = 0;
  logic ovf_exp = 0;

  always #5 clk = ~clk;

  lw_digest_out dut (
    .clk_i(clk), .rst_i(rst), .hash_i(hash), .done_i(done), .abort_i(abort),
    .nwords_i(nwords), .half_last_i(half_last), .out_data_o(out_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_last_o(out_last),
    .busy_o(busy), .overflow_o(overflow), .sent_o(sent)
`ifdef LW_DIGEST_TAG_CMP_EN
    , .exp_tag_i(exp_tag), .tag_ok_o(tag_ok), .tag_vld_o(tag_vld)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic capture(input int n, input logic h);
    for (int k = 0; k < 8; k++) hash[k] = {$urandom, $urandom};
    hash[4] = 64'hAAAA_BBBB_CCCC_DDDD;
    nwords = n[3:0];
    half_last = h;
    done = 1;
    ne = (n == 0) ? 8 : n;
    q.delete();
    for (int j = 0; j < ne; j++) begin
      logic [63:0] w;
      w = hash[7-j];
      if (j == ne - 1 && h) w[31:0] = '0;
      q.push_back(w);
    end
    @(posedge clk); #1;
    done = 0;
    ovf_exp = 0;
  endtask

  // mode: 0 always ready, 1 ready toggling 1010, 2 random ready
  // ev_kind: 1 done pulse, 2 abort, 3 reset, each at cycle ev_cyc
  task automatic drain(input int mode, input int ev_cyc, input int ev_kind);
    int cyc = 0;
    logic pend = 0;
    logic killed = 0;
    logic [63:0] prev = '0;
    while (q.size() > 0 && cyc < 200) begin
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ~cyc[0] : 1'($urandom_range(0, 1));
`ifdef LW_DIGEST_TAG_CMP_EN
      exp_tag = q[0] ^ ((ne - q.size() == flip_beat) ? 64'h8000_0000_0000_0000 : 64'h0);
`endif
      if (cyc == ev_cyc) begin
        if (ev_kind == 1) begin
          done = 1;
          for (int k = 0; k < 8; k++) hash[k] = {$urandom, $urandom};
        end
        if (ev_kind == 2) abort = 1;
        if (ev_kind == 3) rst = 1;
      end
      @(negedge clk);
      chk("valid", {63'b0, out_valid}, 64'd1);
      chk("busy", {63'b0, busy}, 64'd1);
      chk("data", out_data, q[0]);
      chk("last", {63'b0, out_last}, {63'b0, q.size() == 1});
      chk("ovf", {63'b0, overflow}, {63'b0, ovf_exp});
      if (pend) chk("hold", out_data, prev);
      prev = out_data;
      @(posedge clk); #1;
      done = 0;
      if (cyc == ev_cyc && ev_kind == 1) ovf_exp = 1;
      if (cyc == ev_cyc && ev_kind >= 2) begin
        if (ev_kind == 3) ovf_exp = 0;
        abort = 0;
        rst = 0;
        killed = 1;
        q.delete();
        break;
      end
      pend = !out_ready;
      if (out_ready) void'(q.pop_front());
      cyc++;
    end
    if (cyc >= 200) chk("timeout", 64'(cyc), 64'd0);
    out_ready = 0;
    @(negedge clk);
    chk("sent", {63'b0, sent}, {63'b0, !killed});
    chk("valid_end", {63'b0, out_valid}, 64'd0);
    chk("busy_end", {63'b0, busy}, 64'd0);
    chk("last_end", {63'b0, out_last}, 64'd0);
    chk("data_end", out_data, 64'd0);
    chk("ovf_end", {63'b0, overflow}, {63'b0, ovf_exp});
    for (int k = 0; k < 8; k++) chk("zero", dut.mem[k], 64'd0);
`ifdef LW_DIGEST_TAG_CMP_EN
    if (!killed) begin
      chk("tag_vld", {63'b0, tag_vld}, 64'd1);
      chk("tag_ok", {63'b0, tag_ok}, {63'b0, flip_beat < 0 || flip_beat >= ne});
    end
`endif
    @(posedge clk); #1;
    chk("sent_pulse", {63'b0, sent}, 64'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_last", {63'b0, out_last}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_ovf", {63'b0, overflow}, 64'd0);
    chk("rst_sent", {63'b0, sent}, 64'd0);
    chk("rst_data", out_data, 64'd0);
    @(posedge clk); #1;
    capture(8, 0); drain(0, -1, 0);
    capture(6, 0); drain(1, -1, 0);
    capture(4, 1); drain(2, -1, 0);
    capture(8, 0); drain(0, 2, 1);
    capture(0, 0); drain(2, -1, 0);
    capture(3, 0); drain(0, 2, 1);
    capture(8, 0); drain(0, 1, 2);
    capture(5, 1); drain(1, 2, 3);
    for (int i = 0; i < 10; i++) begin
      capture($urandom_range(1, 8), 1'($urandom_range(0, 1)));
      drain(2, -1, 0);
    end
`ifdef LW_DIGEST_TAG_CMP_EN
    flip_beat = 4;
    capture(8, 0); drain(0, -1, 0);
    flip_beat = -1;
    capture(7, 1); drain(1, -1, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
